// File: rtl/vga_pixel_gen.sv
// Circle pixel generator: a three-strobe distance pipeline behind the VGA timing stage,
// plus a once-per-frame radius animator (hold, breathe, grow-and-wrap).
module vga_pixel_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CX       = 320,
    parameter int CY       = 240,
    parameter int R_DEF    = 100,
    parameter int R_MIN    = 16,
    parameter int R_MAX    = 200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_en,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic       i_hblank,
    input  logic       i_vblank,
    input  logic [1:0] i_sel,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_red,
    output logic       o_grn,
    output logic       o_blu,
    output logic [9:0] o_radius,
    output logic       o_frame_start
);

    localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [8:0]  Y_LAST  = 9'(V_ACTIVE - 1);
    localparam logic [10:0] CX_W    = 11'(CX);
    localparam logic [10:0] CY_W    = 11'(CY);
    localparam logic [9:0]  RAD_DEF = 10'(R_DEF);
    localparam logic [9:0]  RAD_MIN = 10'(R_MIN);
    localparam logic [9:0]  RAD_MAX = 10'(R_MAX);
    localparam logic [19:0] RSQ_DEF = 20'(R_DEF * R_DEF);

    typedef enum logic [1:0] {HOLD, GROW, SHRINK, WRAP} radius_state_t;

    radius_state_t state_q, state_d;
    logic [9:0]  radius_q, radius_d;
    logic [19:0] rsq_q, rsq_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        hb_prev_q, hb_prev_d;
    logic        vb_prev_q, vb_prev_d;
    logic        locked_q, locked_d;
    logic        frame_start_q, frame_start_d;

    logic [10:0] dx1_q, dx1_d, dy1_q, dy1_d;
    logic        border1_q, border1_d, blk1_q, blk1_d;
    logic        hs1_q, hs1_d, vs1_q, vs1_d;
    logic [20:0] dxsq2_q, dxsq2_d, dysq2_q, dysq2_d;
    logic        border2_q, border2_d, blk2_q, blk2_d;
    logic        hs2_q, hs2_d, vs2_q, vs2_d;
    logic [2:0]  rgb3_q, rgb3_d;
    logic        hs3_q, hs3_d, vs3_q, vs3_d;

    logic        hb_rise, vb_rise, vb_fall;
    logic [10:0] adx, ady;
    logic [21:0] dist_sq;
    logic [9:0]  wrap_radius;

    // locked_q holds off frame starts and drawing until a vblank has been seen after reset
    assign hb_rise     = i_pix_en & i_hblank & ~hb_prev_q;
    assign vb_rise     = i_pix_en & i_vblank & ~vb_prev_q;
    assign vb_fall     = i_pix_en & ~i_vblank & vb_prev_q & locked_q;
    assign adx         = dx1_q[10] ? (11'd0 - dx1_q) : dx1_q;
    assign ady         = dy1_q[10] ? (11'd0 - dy1_q) : dy1_q;
    assign dist_sq     = {1'b0, dxsq2_q} + {1'b0, dysq2_q};
    assign wrap_radius = radius_q + 10'd2;

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        hb_prev_d = hb_prev_q;
        vb_prev_d = vb_prev_q;
        locked_d  = locked_q | (i_pix_en & i_vblank);
        if (i_pix_en) begin
            hb_prev_d = i_hblank;
            vb_prev_d = i_vblank;
            if (i_hblank) begin
                x_d = '0;
            end else if (x_q != X_LAST) begin
                x_d = x_q + 10'd1;
            end
            if (i_vblank) begin
                y_d = '0;
            end else if (hb_rise && (y_q != Y_LAST)) begin
                y_d = y_q + 9'd1;
            end
        end
        frame_start_d = vb_fall;
        rsq_d         = vb_fall ? (20'(radius_q) * 20'(radius_q)) : rsq_q;
    end

    // Breathe and wrap keep stepping from whatever radius is current when the mode changes
    always_comb begin
        state_d  = state_q;
        radius_d = radius_q;
        if (vb_rise) begin
            case (i_sel)
                2'b01: begin
                    if (state_q == SHRINK) begin
                        if (radius_q <= RAD_MIN) begin
                            state_d  = GROW;
                            radius_d = radius_q + 10'd1;
                        end else begin
                            radius_d = radius_q - 10'd1;
                        end
                    end else if (radius_q >= RAD_MAX) begin
                        state_d  = SHRINK;
                        radius_d = radius_q - 10'd1;
                    end else begin
                        state_d  = GROW;
                        radius_d = radius_q + 10'd1;
                    end
                end
                2'b10: begin
                    state_d  = WRAP;
                    radius_d = (wrap_radius > RAD_MAX) ? RAD_MIN : wrap_radius;
                end
                default: begin
                    state_d  = HOLD;
                    radius_d = RAD_DEF;
                end
            endcase
        end
    end

    always_comb begin
        dx1_d     = dx1_q;
        dy1_d     = dy1_q;
        border1_d = border1_q;
        blk1_d    = blk1_q;
        hs1_d     = hs1_q;
        vs1_d     = vs1_q;
        dxsq2_d   = dxsq2_q;
        dysq2_d   = dysq2_q;
        border2_d = border2_q;
        blk2_d    = blk2_q;
        hs2_d     = hs2_q;
        vs2_d     = vs2_q;
        rgb3_d    = rgb3_q;
        hs3_d     = hs3_q;
        vs3_d     = vs3_q;
        if (i_pix_en) begin
            dx1_d     = {1'b0, x_q} - CX_W;
            dy1_d     = {2'b00, y_q} - CY_W;
            border1_d = (x_q == 10'd0) || (x_q == X_LAST) || (y_q == 9'd0) || (y_q == Y_LAST);
            blk1_d    = i_hblank | i_vblank | ~locked_q;
            hs1_d     = i_hsync;
            vs1_d     = i_vsync;
            dxsq2_d   = 21'(adx) * 21'(adx);
            dysq2_d   = 21'(ady) * 21'(ady);
            border2_d = border1_q;
            blk2_d    = blk1_q;
            hs2_d     = hs1_q;
            vs2_d     = vs1_q;
            hs3_d     = hs2_q;
            vs3_d     = vs2_q;
            if (blk2_q || (i_sel == 2'b11)) begin
                rgb3_d = 3'b000;
            end else if (border2_q) begin
                rgb3_d = 3'b100;
            end else if (dist_sq < {2'b00, rsq_q}) begin
                rgb3_d = 3'b111;
            end else begin
                rgb3_d = 3'b000;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= HOLD;
            radius_q      <= RAD_DEF;
            rsq_q         <= RSQ_DEF;
            x_q           <= '0;
            y_q           <= '0;
            hb_prev_q     <= 1'b1;
            vb_prev_q     <= 1'b1;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            radius_q      <= radius_d;
            rsq_q         <= rsq_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hb_prev_q     <= hb_prev_d;
            vb_prev_q     <= vb_prev_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dx1_q     <= '0;
            dy1_q     <= '0;
            border1_q <= 1'b0;
            blk1_q    <= 1'b1;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            dxsq2_q   <= '0;
            dysq2_q   <= '0;
            border2_q <= 1'b0;
            blk2_q    <= 1'b1;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            rgb3_q    <= 3'b000;
            hs3_q     <= 1'b1;
            vs3_q     <= 1'b1;
        end else begin
            dx1_q     <= dx1_d;
            dy1_q     <= dy1_d;
            border1_q <= border1_d;
            blk1_q    <= blk1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            dxsq2_q   <= dxsq2_d;
            dysq2_q   <= dysq2_d;
            border2_q <= border2_d;
            blk2_q    <= blk2_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            rgb3_q    <= rgb3_d;
            hs3_q     <= hs3_d;
            vs3_q     <= vs3_d;
        end
    end

    assign o_hsync       = hs3_q;
    assign o_vsync       = vs3_q;
    assign o_red         = rgb3_q[2];
    assign o_grn         = rgb3_q[1];
    assign o_blu         = rgb3_q[0];
    assign o_radius      = radius_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Directed bench for vga_pixel_gen on a shrunken 16x12 screen (20x15 total strobes per frame)
// with a small radius range so every animation boundary is reached in a few frames.
module tb_vga_pixel_gen;

    logic       i_clk;
    logic       i_rst;
    logic       i_pix_en;
    logic       i_hsync;
    logic       i_vsync;
    logic       i_hblank;
    logic       i_vblank;
    logic [1:0] i_sel;
    logic       o_hsync;
    logic       o_vsync;
    logic       o_red;
    logic       o_grn;
    logic       o_blu;
    logic [9:0] o_radius;
    logic       o_frame_start;

    int checks   = 0;
    int failures = 0;

    int   hx [3];
    int   hy [3];
    bit   hv [3];
    logic [2:0] fb [16][12];
    int   litCount;
    int   hsLow;
    int   vsLow;
    int   fsCount;

    int breatheExp [12] = '{5, 6, 7, 6, 5, 4, 3, 2, 3, 4, 5, 6};
    int wrapExp [4]     = '{2, 4, 6, 2};

    vga_pixel_gen #(
        .H_ACTIVE (16),
        .V_ACTIVE (12),
        .CX       (8),
        .CY       (6),
        .R_DEF    (4),
        .R_MIN    (2),
        .R_MAX    (7)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pix_en      (i_pix_en),
        .i_hsync       (i_hsync),
        .i_vsync       (i_vsync),
        .i_hblank      (i_hblank),
        .i_vblank      (i_vblank),
        .i_sel         (i_sel),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_red         (o_red),
        .o_grn         (o_grn),
        .o_blu         (o_blu),
        .o_radius      (o_radius),
        .o_frame_start (o_frame_start)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [2:0] rgb();
        return {o_red, o_grn, o_blu};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic strobe();
        i_pix_en = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idleCycle();
        i_pix_en = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic clearStats();
        litCount = 0;
        hsLow    = 0;
        vsLow    = 0;
        fsCount  = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 12; y++) begin
                fb[x][y] = 3'bxxx;
            end
        end
    endtask

    // One strobe of frame position k: lines 0-2 are vblank, cols 16-19 are hblank.
    // The output seen after strobe k belongs to the pixel driven at strobe k-2.
    task automatic applyStimulus(input int k);
        int line;
        int col;
        line     = k / 20;
        col      = k % 20;
        i_hblank = (col >= 16);
        i_vblank = (line < 3);
        i_hsync  = !((col == 17) || (col == 18));
        i_vsync  = !(line == 1);
        strobe();
        hx[2] = hx[1]; hy[2] = hy[1]; hv[2] = hv[1];
        hx[1] = hx[0]; hy[1] = hy[0]; hv[1] = hv[0];
        hx[0] = col;   hy[0] = line - 3; hv[0] = (col < 16) && (line >= 3);
        if (hv[2]) fb[hx[2]][hy[2]] = rgb();
        if (rgb() != 3'b000) litCount++;
        if (!o_hsync) hsLow++;
        if (!o_vsync) vsLow++;
        if (o_frame_start) fsCount++;
    endtask

    task automatic runRange(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            applyStimulus(k);
        end
    endtask

    task automatic runFrame();
        clearStats();
        runRange(0, 299);
    endtask

    task automatic shortFrame();
        i_hblank = 1'b1;
        i_hsync  = 1'b1;
        i_vsync  = 1'b1;
        i_vblank = 1'b0;
        strobe();
        strobe();
        i_vblank = 1'b1;
        strobe();
        strobe();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            hx[i] = 0; hy[i] = 0; hv[i] = 1'b0;
        end
        i_rst    = 1'b1;
        i_pix_en = 1'b0;
        i_hsync  = 1'b1;
        i_vsync  = 1'b1;
        i_hblank = 1'b1;
        i_vblank = 1'b1;
        i_sel    = 2'b00;
        repeat (3) idleCycle();

        checkOutput("rst_hsync", 32'(o_hsync), 32'd1);
        checkOutput("rst_vsync", 32'(o_vsync), 32'd1);
        checkOutput("rst_rgb", 32'(rgb()), 32'd0);
        checkOutput("rst_frame_start", 32'(o_frame_start), 32'd0);
        checkOutput("rst_radius", 32'(o_radius), 32'd4);
        i_rst = 1'b0;

        // Static circle, r=4 -> r*r=16 centred on (8,6)
        runFrame();
        checkOutput("s0_centre", 32'(fb[8][6]), 32'd7);
        checkOutput("s0_in_11_6", 32'(fb[11][6]), 32'd7);
        checkOutput("s0_edge_12_6", 32'(fb[12][6]), 32'd0);
        checkOutput("s0_edge_8_2", 32'(fb[8][2]), 32'd0);
        checkOutput("s0_in_5_4", 32'(fb[5][4]), 32'd7);
        checkOutput("s0_out_1_6", 32'(fb[1][6]), 32'd0);
        checkOutput("s0_border_0_0", 32'(fb[0][0]), 32'd4);
        checkOutput("s0_border_15_6", 32'(fb[15][6]), 32'd4);
        checkOutput("s0_border_8_11", 32'(fb[8][11]), 32'd4);
        checkOutput("s0_frame_starts", 32'(fsCount), 32'd1);
        checkOutput("s0_radius", 32'(o_radius), 32'd4);

        // Single-strobe hsync pulse must emerge three strobes later, ignoring idle cycles
        i_hblank = 1'b1;
        i_vblank = 1'b1;
        i_hsync  = 1'b1;
        i_vsync  = 1'b1;
        repeat (3) strobe();
        checkOutput("hs_idle", 32'(o_hsync), 32'd1);
        i_hsync = 1'b0;
        strobe();
        checkOutput("hs_after_n", 32'(o_hsync), 32'd1);
        i_hsync = 1'b1;
        idleCycle();
        idleCycle();
        checkOutput("hs_nonstrobe_early", 32'(o_hsync), 32'd1);
        strobe();
        checkOutput("hs_after_n1", 32'(o_hsync), 32'd1);
        strobe();
        checkOutput("hs_at_n3", 32'(o_hsync), 32'd0);
        idleCycle();
        idleCycle();
        checkOutput("hs_nonstrobe_hold", 32'(o_hsync), 32'd0);
        strobe();
        checkOutput("hs_release", 32'(o_hsync), 32'd1);

        // Video off: nothing lit, syncs keep their full pattern
        i_sel = 2'b11;
        runFrame();
        runFrame();
        checkOutput("off_lit", 32'(litCount), 32'd0);
        checkOutput("off_hsync_low", 32'(hsLow), 32'd30);
        checkOutput("off_vsync_low", 32'(vsLow), 32'd20);
        checkOutput("off_frame_starts", 32'(fsCount), 32'd1);

        // Breathe for one full frame: r=5 -> r*r=25
        i_sel = 2'b01;
        runFrame();
        checkOutput("r5_radius", 32'(o_radius), 32'd5);
        checkOutput("r5_in_12_6", 32'(fb[12][6]), 32'd7);
        checkOutput("r5_edge_13_6", 32'(fb[13][6]), 32'd0);
        checkOutput("r5_edge_8_1", 32'(fb[8][1]), 32'd0);
        checkOutput("r5_in_8_2", 32'(fb[8][2]), 32'd7);

        // Asynchronous reset in the middle of visible line y=6
        clearStats();
        runRange(0, 190);
        checkOutput("pre_rst_rgb", 32'(rgb()), 32'd7);
        checkOutput("pre_rst_radius", 32'(o_radius), 32'd6);
        i_pix_en = 1'b0;
        #3;
        i_rst = 1'b1;
        #1;
        checkOutput("mid_rst_rgb", 32'(rgb()), 32'd0);
        checkOutput("mid_rst_radius", 32'(o_radius), 32'd4);
        checkOutput("mid_rst_hsync", 32'(o_hsync), 32'd1);
        checkOutput("mid_rst_vsync", 32'(o_vsync), 32'd1);
        checkOutput("mid_rst_frame_start", 32'(o_frame_start), 32'd0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        runRange(191, 299);
        i_sel = 2'b00;
        runFrame();
        checkOutput("post_rst_centre", 32'(fb[8][6]), 32'd7);
        checkOutput("post_rst_in_11_6", 32'(fb[11][6]), 32'd7);
        checkOutput("post_rst_edge_12_6", 32'(fb[12][6]), 32'd0);
        checkOutput("post_rst_border_0_0", 32'(fb[0][0]), 32'd4);
        checkOutput("post_rst_radius", 32'(o_radius), 32'd4);
        checkOutput("post_rst_frame_starts", 32'(fsCount), 32'd1);

        // Breathe over short frames; a mode change inside vblank must wait for the next frame
        i_sel = 2'b01;
        shortFrame();
        checkOutput("breathe0", 32'(o_radius), 32'(breatheExp[0]));
        i_sel = 2'b00;
        strobe();
        strobe();
        checkOutput("midframe_sel", 32'(o_radius), 32'd5);
        i_sel = 2'b01;
        for (int i = 1; i < 12; i++) begin
            shortFrame();
            checkOutput($sformatf("breathe%0d", i), 32'(o_radius), 32'(breatheExp[i]));
        end

        // Grow-wrap from 6: 8 exceeds the maximum so it restarts at the minimum
        i_sel = 2'b10;
        for (int i = 0; i < 4; i++) begin
            shortFrame();
            checkOutput($sformatf("wrap%0d", i), 32'(o_radius), 32'(wrapExp[i]));
        end

        i_sel = 2'b00;
        shortFrame();
        checkOutput("hold_return", 32'(o_radius), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_pixel_gen.md
VGA_PIXEL_GEN -- requirements
Module: vga_pixel_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-003 Parameter CX, 320, circle centre x.
REQ-004 Parameter CY, 240, circle centre y.
REQ-005 Parameter R_DEF, 100, static and reset radius.
REQ-006 Parameter R_MIN, 16, lower radius bound for animation.
REQ-007 Parameter R_MAX, 200, upper radius bound for animation.
REQ-008 Port i_clk, input, 1, the single clock.
REQ-009 Port i_rst, input, 1, reset, asynchronous, active-high.
REQ-010 Port i_pix_en, input, 1, pixel strobe; all pipeline and counter state advances only on cycles with i_pix_en=1.
REQ-011 Port i_hsync / i_vsync, input, 1 each, active-low syncs from the timing stage.
REQ-012 Port i_hblank / i_vblank, input, 1 each, blanking flags from the timing stage; 1 = blanked.
REQ-013 Port i_sel, input, 2, mode: 00 static, 01 breathe, 10 grow-wrap, 11 video off.
REQ-014 Port o_hsync / o_vsync, output, 1 each, syncs delayed to match pixel latency.
REQ-015 Port o_red / o_grn / o_blu, output, 1 each, pixel colour.
REQ-016 Port o_radius, output, 10, current frame radius.
REQ-017 Port o_frame_start, output, 1, one-cycle pulse on the first strobe after i_vblank falls.

Function
REQ-018 x counter (10 bit) SHALL clear while i_hblank=1 and increment per strobe while i_hblank=0.
REQ-019 y counter (9 bit) SHALL clear while i_vblank=1 and increment on the strobe where i_hblank rises 0->1.
REQ-020 Both counters SHALL saturate at H_ACTIVE-1 / V_ACTIVE-1 if blanking arrives late.
REQ-021 Pipeline is 3 strobes: S1 signed dx=x-CX, dy=y-CY (11 bit); S2 dx*dx, dy*dy (21 bit unsigned); S3 sum (22 bit) compared against r*r (20 bit, registered at frame start).
REQ-022 i_hsync, i_vsync, i_hblank and i_vblank SHALL pass through the same 3-stage delay; o_hsync/o_vsync are the stage-3 copies.
REQ-023 Colour: delayed blank=1 or i_sel=11 -> 000; else border pixel (x=0, x=H_ACTIVE-1, y=0, y=V_ACTIVE-1) -> 100; else sum<r*r -> 111; else 000.
REQ-024 Radius FSM states HOLD, GROW, SHRINK, WRAP; evaluated once per frame on the strobe where i_vblank rises.
REQ-025 HOLD: radius=R_DEF; i_sel=01 -> GROW; i_sel=10 -> WRAP.
REQ-026 GROW: radius+1; at R_MAX -> SHRINK.
REQ-027 SHRINK: radius-1; at R_MIN -> GROW.
REQ-028 WRAP: radius+2; if result >R_MAX then radius=R_MIN.
REQ-029 Any state with i_sel=00 or 11 -> HOLD at the next frame evaluation; a mode change SHALL NOT take effect mid-frame.
REQ-030 r*r register SHALL update only on o_frame_start, so a frame never shows two radii.
REQ-031 Simultaneous hblank rise and vblank rise: y clears, and the FSM step occurs.

Reset
REQ-032 While i_rst=1: o_hsync=1, o_vsync=1, colours 000, o_frame_start=0, o_radius=R_DEF, FSM=HOLD, x=y=0, all delay stages hold blank=1 and sync=1.
REQ-033 Reset asserted mid-line SHALL force outputs to reset values immediately, without waiting for a clock edge; operation resumes at the next blanking transition.

Verification
REQ-034 i_sel=00, one full 800x525 frame -> pixel (320,240) white, (100,240) black, (0,0) red, o_radius=100.
REQ-035 Drive i_hsync low at strobe n -> o_hsync low at strobe n+3; no change on non-strobe cycles.
REQ-036 i_sel=01 from reset -> o_radius 101,102,... per frame, reaching 200 and then 199.
REQ-037 i_sel=10 with radius=199 -> next frame 16.
REQ-038 i_sel=11 -> all colours 000 for the whole frame, syncs unchanged.
REQ-039 Assert i_rst at x=200, y=100 -> outputs at reset values within the same cycle; first visible frame after release is correct.
